// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// byte/timeout constants.
package uart_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_DRAIN
  } arbState_t;

  localparam int UART_BYTE_W   = 8;
  localparam int ISSUE_TIMEOUT = 255;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the start
// pointer (wrapping), returned as one-hot grant plus binary index.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  int          candInt;
  logic [IW-1:0] cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    candInt = 0;
    cand    = '0;
    for (int off = 0; off < N_REQ; off++) begin
      candInt = int'(i_ptr) + off;
      if (candInt >= N_REQ) candInt = candInt - N_REQ;
      cand = IW'(candInt);
      if (!o_any && i_req[cand]) begin
        o_any         = 1'b1;
        o_grant[cand] = 1'b1;
        o_idx         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte-stream
// requesters; a grant is held for a whole packet so packets never interleave.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_PKT = 16,
  parameter int SETTLE  = 2
) (
  input  logic                        clk_x4,
  input  logic                        rst_x,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [UART_BYTE_W*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]            i_req_last,
  output logic [N_REQ-1:0]            o_req_ack,
  output logic [N_REQ-1:0]            o_grant,
  output logic [UART_BYTE_W-1:0]      o_uart_data,
  output logic                        o_uart_valid,
  input  logic                        i_uart_busy,
  input  logic                        i_uart_error,
  output logic                        o_error
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_PKT + 1);
  localparam int SW = $clog2(SETTLE + 1);

  arbState_t              state_q;
  logic [N_REQ-1:0]       grant_q, ack_q, pickGrant;
  logic [IW-1:0]          owner_q, rrPtr_q, pickIdx, rrNext_d;
  logic                   pickAny;
  logic [CW-1:0]          count_q, count_d;
  logic                   last_q;
  logic [SW-1:0]          settle_q;
  logic [7:0]             tmo_q;
  logic [UART_BYTE_W-1:0] data_q, ownerByte_d;
  logic                   valid_q, error_q;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .i_req   (i_req),
    .i_ptr   (rrPtr_q),
    .o_grant (pickGrant),
    .o_idx   (pickIdx),
    .o_any   (pickAny)
  );

  always_comb begin
    ownerByte_d = i_req_data[int'(owner_q)*UART_BYTE_W +: UART_BYTE_W];
    count_d     = (count_q == CW'(MAX_PKT)) ? count_q : count_q + CW'(1);
    rrNext_d    = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + IW'(1);
  end

  // A stalled owner keeps the grant in ISSUE/DRAIN: packet integrity beats fairness.
  always_ff @(posedge clk_x4 or posedge rst_x) begin
    if (rst_x) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rrPtr_q  <= '0;
      count_q  <= '0;
      last_q   <= 1'b0;
      settle_q <= '0;
      tmo_q    <= '0;
      ack_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      ack_q   <= '0;
      valid_q <= 1'b0;
      if (i_uart_error) error_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (pickAny) begin
            grant_q <= pickGrant;
            owner_q <= pickIdx;
            tmo_q   <= '0;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_uart_busy) begin
            if (tmo_q == 8'(ISSUE_TIMEOUT)) begin
              error_q <= 1'b1;
              grant_q <= '0;
              count_q <= '0;
              rrPtr_q <= rrNext_d;
              tmo_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              tmo_q <= tmo_q + 8'd1;
            end
          end else begin
            tmo_q <= '0;
            if (i_req[owner_q]) begin
              valid_q  <= 1'b1;
              data_q   <= ownerByte_d;
              ack_q    <= grant_q;
              count_q  <= count_d;
              last_q   <= i_req_last[owner_q];
              settle_q <= '0;
              state_q  <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_q == SW'(SETTLE - 1)) state_q <= ST_DRAIN;
          else settle_q <= settle_q + SW'(1);
        end
        ST_DRAIN: begin
          if (!i_uart_busy) begin
            if (last_q || count_q == CW'(MAX_PKT)) begin
              grant_q <= '0;
              count_q <= '0;
              rrPtr_q <= rrNext_d;
              state_q <= ST_IDLE;
            end else if (i_req[owner_q]) begin
              tmo_q   <= '0;
              state_q <= ST_ISSUE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ack    = ack_q;
  assign o_grant      = grant_q;
  assign o_uart_data  = data_q;
  assign o_uart_valid = valid_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queued requester models, a busy
// transmitter model, a wire log, and a table of per-scenario expected bytes.
module tb_uart_tx_arbiter;
  localparam int N        = 4;
  localparam int BUSY_LEN = 10;

  logic           clock;
  logic           rst_x;
  logic [N-1:0]   i_req, i_req_last, o_req_ack, o_grant;
  logic [8*N-1:0] i_req_data;
  logic [7:0]     o_uart_data;
  logic           o_uart_valid, i_uart_busy, i_uart_error, o_error;

  uart_tx_arbiter #(.N_REQ(N), .MAX_PKT(16), .SETTLE(2)) dut (
    .clk_x4       (clock),
    .rst_x        (rst_x),
    .i_req        (i_req),
    .i_req_data   (i_req_data),
    .i_req_last   (i_req_last),
    .o_req_ack    (o_req_ack),
    .o_grant      (o_grant),
    .o_uart_data  (o_uart_data),
    .o_uart_valid (o_uart_valid),
    .i_uart_busy  (i_uart_busy),
    .i_uart_error (i_uart_error),
    .o_error      (o_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int         scen;
    int         req;
    logic [7:0] data;
    logic       last;
    int         expPos;
  } vec_t;

  typedef struct {
    int         ackSrc;
    int         grantSrc;
    logic [7:0] data;
  } wire_t;

  vec_t       vecs[$];
  wire_t      wireLog[$];
  logic [8:0] reqQ[N][$];
  int         ackCnt[N];
  int         stallAt[N];
  int         stallLen[N];
  int         stallRem[N];
  int         busyCnt;
  bit         forceBusy;
  int         tests = 0;
  int         failures = 0;

  function automatic int ohIdx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v == (N'(1) << k)) return k;
    return -1;
  endfunction

  function automatic logic [31:0] packWire(input int a, input int g, input logic [7:0] d);
    return {8'h00, 8'(a), 8'(g), d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failBound(input string name);
    tests++;
    failures++;
    $display("[TB] FAIL %s: condition not reached within its cycle budget", name);
  endtask

  task automatic addVec(input int s, input int r, input logic [7:0] d, input logic l, input int p);
    vec_t v;
    v.scen = s; v.req = r; v.data = d; v.last = l; v.expPos = p;
    vecs.push_back(v);
  endtask

  // Requester and transmitter models run on the falling edge, away from the DUT's sampling edge.
  initial begin
    i_req = '0; i_req_data = '0; i_req_last = '0; i_uart_busy = 1'b0;
    busyCnt = 0; forceBusy = 1'b0;
    for (int k = 0; k < N; k++) begin
      ackCnt[k] = 0; stallAt[k] = -1; stallLen[k] = 0; stallRem[k] = 0;
    end
    forever begin
      @(negedge clock);
      if (rst_x) begin
        for (int k = 0; k < N; k++) begin
          reqQ[k].delete();
          stallRem[k] = 0;
        end
        busyCnt = 0;
      end else begin
        if (o_uart_valid) begin
          wire_t w;
          w.ackSrc = ohIdx(o_req_ack); w.grantSrc = ohIdx(o_grant); w.data = o_uart_data;
          wireLog.push_back(w);
          busyCnt = BUSY_LEN;
        end else if (busyCnt > 0) begin
          busyCnt--;
        end
        for (int k = 0; k < N; k++) begin
          if (stallRem[k] > 0) stallRem[k]--;
          if (o_req_ack[k]) begin
            ackCnt[k]++;
            if (reqQ[k].size() > 0) void'(reqQ[k].pop_front());
            if (ackCnt[k] == stallAt[k]) stallRem[k] = stallLen[k];
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (reqQ[k].size() > 0 && stallRem[k] == 0) begin
          i_req[k] = 1'b1;
          i_req_data[8*k +: 8] = reqQ[k][0][7:0];
          i_req_last[k] = reqQ[k][0][8];
        end else begin
          i_req[k] = 1'b0;
          i_req_data[8*k +: 8] = 8'h00;
          i_req_last[k] = 1'b0;
        end
      end
      i_uart_busy = (busyCnt > 0) || forceBusy;
    end
  end

  task automatic applyStimulus(input int s);
    for (int k = 0; k < N; k++) ackCnt[k] = 0;
    foreach (vecs[i])
      if (vecs[i].scen == s) reqQ[vecs[i].req].push_back({vecs[i].last, vecs[i].data});
  endtask

  task automatic waitQuiet(input string name, input int budget);
    int  i;
    bit  empty;
    for (i = 0; i < budget; i++) begin
      @(negedge clock);
      empty = 1'b1;
      for (int k = 0; k < N; k++) if (reqQ[k].size() != 0) empty = 1'b0;
      if (empty && o_grant == '0 && busyCnt == 0 && !forceBusy) break;
    end
    if (i == budget) failBound(name);
  endtask

  task automatic waitAck(input string name, input int k, input int n, input int budget);
    int i;
    for (i = 0; i < budget && ackCnt[k] < n; i++) @(negedge clock);
    if (ackCnt[k] < n) failBound(name);
  endtask

  task automatic checkScenario(input int s, input int base);
    int expCnt;
    int expAck[N];
    int idx;
    expCnt = 0;
    for (int k = 0; k < N; k++) expAck[k] = 0;
    foreach (vecs[i]) begin
      if (vecs[i].scen == s && vecs[i].expPos >= 0) begin
        expCnt++;
        expAck[vecs[i].req]++;
        idx = base + vecs[i].expPos;
        if (idx < wireLog.size())
          checkOutput($sformatf("s%0d_byte%0d", s, vecs[i].expPos),
                      packWire(wireLog[idx].ackSrc, wireLog[idx].grantSrc, wireLog[idx].data),
                      packWire(vecs[i].req, vecs[i].req, vecs[i].data));
        else
          failBound($sformatf("s%0d_byte%0d_present", s, vecs[i].expPos));
      end
    end
    checkOutput($sformatf("s%0d_byteCount", s), 32'(wireLog.size() - base), 32'(expCnt));
    for (int k = 0; k < N; k++)
      checkOutput($sformatf("s%0d_ackCount%0d", s, k), 32'(ackCnt[k]), 32'(expAck[k]));
  endtask

  task automatic doReset();
    rst_x = 1'b1;
    repeat (2) @(negedge clock);
    rst_x = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int base;
    int i;
    rst_x = 1'b1;
    i_uart_error = 1'b0;

    addVec(1, 0, 8'hA5, 1'b0, 0); addVec(1, 0, 8'h5A, 1'b0, 1); addVec(1, 0, 8'hFF, 1'b1, 2);
    addVec(2, 0, 8'h11, 1'b1, 1); addVec(2, 1, 8'h22, 1'b1, 0);
    addVec(3, 0, 8'h01, 1'b0, 0); addVec(3, 0, 8'h02, 1'b1, 1);
    addVec(3, 2, 8'h21, 1'b0, 2); addVec(3, 2, 8'h22, 1'b1, 3);
    for (int b = 0; b < 20; b++) addVec(4, 1, 8'(8'h40 + b), (b == 19), (b < 16) ? b : b + 1);
    addVec(4, 3, 8'h33, 1'b1, 16);
    addVec(5, 2, 8'hC1, 1'b0, 0); addVec(5, 2, 8'hC2, 1'b0, 1); addVec(5, 2, 8'hC3, 1'b1, 2);
    addVec(5, 0, 8'h0A, 1'b1, 3);
    addVec(6, 3, 8'h71, 1'b0, 0); addVec(6, 3, 8'h72, 1'b0, 1); addVec(6, 3, 8'h73, 1'b1, 2);
    addVec(7, 1, 8'hE7, 1'b1, 0);
    addVec(8, 0, 8'hB0, 1'b0, 0); addVec(8, 0, 8'hB1, 1'b0, -1); addVec(8, 0, 8'hB2, 1'b1, -1);
    addVec(9, 0, 8'h0C, 1'b1, 0); addVec(9, 2, 8'h2C, 1'b1, 1);

    repeat (3) @(negedge clock);
    checkOutput("rstGrant", 32'(o_grant), 32'h0);
    checkOutput("rstAck", 32'(o_req_ack), 32'h0);
    checkOutput("rstValid", 32'(o_uart_valid), 32'h0);
    checkOutput("rstData", 32'(o_uart_data), 32'h0);
    checkOutput("rstError", 32'(o_error), 32'h0);
    rst_x = 1'b0;
    @(negedge clock);

    // Table-driven packet scenarios; rr pointer carries over between them unless reset.
    for (int s = 1; s <= 4; s++) begin
      if (s >= 3) doReset();
      base = wireLog.size();
      applyStimulus(s);
      waitQuiet($sformatf("s%0d_quiet", s), 2000);
      checkScenario(s, base);
    end

    stallAt[2] = 1; stallLen[2] = 50;
    base = wireLog.size();
    applyStimulus(5);
    waitAck("s5_firstAck", 2, 1, 100);
    repeat (30) @(negedge clock);
    checkOutput("stallGrantHeld", 32'(o_grant), 32'h4);
    checkOutput("stallReq0NotAcked", 32'(ackCnt[0]), 32'h0);
    waitQuiet("s5_quiet", 2000);
    checkScenario(5, base);
    stallAt[2] = -1;

    checkOutput("errorBefore", 32'(o_error), 32'h0);
    base = wireLog.size();
    applyStimulus(6);
    waitAck("s6_secondAck", 3, 2, 200);
    i_uart_error = 1'b1;
    @(negedge clock);
    i_uart_error = 1'b0;
    @(negedge clock);
    checkOutput("errorSet", 32'(o_error), 32'h1);
    waitQuiet("s6_quiet", 2000);
    checkScenario(6, base);
    checkOutput("errorSticky", 32'(o_error), 32'h1);

    doReset();
    checkOutput("errorClearedByReset", 32'(o_error), 32'h0);
    forceBusy = 1'b1;
    @(negedge clock);
    base = wireLog.size();
    applyStimulus(7);
    for (i = 0; i < 10 && o_grant == '0; i++) @(negedge clock);
    if (o_grant == '0) failBound("tmoGrant");
    repeat (255) @(negedge clock);
    checkOutput("tmoGrantHeld", 32'(o_grant), 32'h2);
    checkOutput("tmoNoErrorYet", 32'(o_error), 32'h0);
    checkOutput("tmoNoByte", 32'(wireLog.size() - base), 32'h0);
    @(negedge clock);
    checkOutput("tmoReleased", 32'(o_grant), 32'h0);
    checkOutput("tmoError", 32'(o_error), 32'h1);
    forceBusy = 1'b0;
    waitQuiet("s7_quiet", 2000);
    checkScenario(7, base);

    base = wireLog.size();
    applyStimulus(8);
    waitAck("s8_firstAck", 0, 1, 100);
    repeat (5) @(negedge clock);
    checkOutput("drainGrant", 32'(o_grant), 32'h1);
    rst_x = 1'b1;
    @(negedge clock);
    checkOutput("midRstGrant", 32'(o_grant), 32'h0);
    checkOutput("midRstValid", 32'(o_uart_valid), 32'h0);
    checkOutput("midRstError", 32'(o_error), 32'h0);
    checkOutput("midRstData", 32'(o_uart_data), 32'h0);
    @(negedge clock);
    rst_x = 1'b0;
    waitQuiet("s8_quiet", 500);
    checkScenario(8, base);

    base = wireLog.size();
    applyStimulus(9);
    waitQuiet("s9_quiet", 2000);
    checkScenario(9, base);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
